// File: rtl/pcs_rx_block_lock_pkg.sv
// Shared types for the 66b receive block-lock path: sync header codes,
// lock FSM states and the header validity check.
package gtype;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  typedef enum logic [2:0] {
    RESET_CNT,
    TEST_SH,
    LOCKED,
    SLIP,
    SLIP_WAIT
  } lock_state_t;

  // Only the two transition headers are legal; 00 and 11 mean misalignment or bit errors.
  function automatic logic hdr_is_valid(input logic [1:0] h);
    return (h == SYNC_DATA) || (h == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/pcs_rx_block_lock_if.sv
// Gearbox-to-PCS header bus plus the lock/BER status returned to the link logic.
interface pcs_rx_block_lock_if;

  logic [1:0] hdr;
  logic       hdr_valid;
  logic       pma_slip;
  logic       block_lock;
  logic       hi_ber;
  logic [7:0] err_cnt;

  modport master (
    output hdr,
    output hdr_valid,
    input  pma_slip,
    input  block_lock,
    input  hi_ber,
    input  err_cnt
  );

  modport slave (
    input  hdr,
    input  hdr_valid,
    output pma_slip,
    output block_lock,
    output hi_ber,
    output err_cnt
  );

endinterface

// File: rtl/pcs_rx_block_lock_ber_mon.sv
// BER monitor: counts invalid headers per window of blocks and raises hi_ber
// when a window reaches BER_MAX. Held in reset whenever block lock is absent.
module pcs_rx_ber_mon #(
  parameter int BER_WINDOW = 19531,
  parameter int BER_MAX    = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic hdr_strobe,
  input  logic hdr_invalid,
  output logic hi_ber
);

  import gtype::*;

  localparam int WIN_W = $clog2(BER_WINDOW + 1);
  localparam int BER_W = $clog2(BER_MAX + 1);
  localparam logic [WIN_W-1:0] BER_WINDOW_V = WIN_W'(BER_WINDOW);
  localparam logic [BER_W-1:0] BER_MAX_V    = BER_W'(BER_MAX);

  logic [WIN_W-1:0] win_cnt;
  logic [WIN_W-1:0] win_next;
  logic [BER_W-1:0] ber_cnt;
  logic [BER_W-1:0] ber_next;

  always_comb begin
    win_next = win_cnt + 1'b1;
    ber_next = ber_cnt;
    if (hdr_invalid && (ber_cnt != BER_MAX_V)) begin
      ber_next = ber_cnt + 1'b1;
    end
  end

  // Window end decides hi_ber from the post-update count, so a BER_MAX-th
  // error landing on the last block still flags while the next window starts clean.
  always_ff @(posedge clk) begin
    if (!rst || !en) begin
      win_cnt <= '0;
      ber_cnt <= '0;
      hi_ber  <= 1'b0;
    end else if (hdr_strobe) begin
      if (win_next == BER_WINDOW_V) begin
        win_cnt <= '0;
        ber_cnt <= '0;
        hi_ber  <= (ber_next == BER_MAX_V);
      end else begin
        win_cnt <= win_next;
        ber_cnt <= ber_next;
        if (ber_next == BER_MAX_V) begin
          hi_ber <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pcs_rx_block_lock.sv
// 66b block-lock FSM: hunts for sync-header alignment via PMA bit-slip,
// tracks invalid headers while locked, and hosts the BER monitor.
module pcs_rx_block_lock #(
  parameter int LOCK_CNT     = 64,
  parameter int INVLD_MAX    = 16,
  parameter int SLIP_HOLDOFF = 8,
  parameter int BER_WINDOW   = 19531,
  parameter int BER_MAX      = 16
) (
  input  logic               clk,
  input  logic               rst,
  pcs_rx_block_lock_if.slave bus
);

  import gtype::*;

  localparam int SH_W = $clog2(LOCK_CNT + 1);
  localparam int IV_W = $clog2(INVLD_MAX + 1);
  localparam int HO_W = $clog2(SLIP_HOLDOFF + 1);
  localparam logic [SH_W-1:0] LOCK_CNT_V     = SH_W'(LOCK_CNT);
  localparam logic [IV_W-1:0] INVLD_MAX_V    = IV_W'(INVLD_MAX);
  localparam logic [HO_W-1:0] SLIP_HOLDOFF_V = HO_W'(SLIP_HOLDOFF);

  lock_state_t     state;
  logic [SH_W-1:0] sh_cnt;
  logic [SH_W-1:0] sh_next;
  logic [IV_W-1:0] invld_cnt;
  logic [IV_W-1:0] invld_next;
  logic [HO_W-1:0] hold_cnt;
  logic [HO_W-1:0] hold_next;
  logic            hdr_strobe;
  logic            hdr_invalid;
  logic            pma_slip_r;
  logic            block_lock_r;
  logic [7:0]      err_cnt_r;
  logic            hi_ber_w;

  assign hdr_strobe  = bus.hdr_valid && (state != SLIP_WAIT);
  assign hdr_invalid = !hdr_is_valid(bus.hdr);

  always_comb begin
    sh_next    = sh_cnt + 1'b1;
    invld_next = invld_cnt + IV_W'(hdr_invalid);
    hold_next  = hold_cnt + 1'b1;
  end

  // The SLIP cycle itself is the first holdoff cycle, so SLIP_WAIT exits after
  // SLIP_HOLDOFF-1 more cycles and back-to-back slips land SLIP_HOLDOFF+2 apart.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= RESET_CNT;
      sh_cnt       <= '0;
      invld_cnt    <= '0;
      hold_cnt     <= '0;
      pma_slip_r   <= 1'b0;
      block_lock_r <= 1'b0;
      err_cnt_r    <= '0;
    end else begin
      pma_slip_r <= 1'b0;
      case (state)
        RESET_CNT: begin
          sh_cnt    <= '0;
          invld_cnt <= '0;
          state     <= TEST_SH;
        end
        TEST_SH: begin
          block_lock_r <= 1'b0;
          if (hdr_strobe) begin
            if (hdr_invalid) begin
              state <= SLIP;
            end else if (sh_next == LOCK_CNT_V) begin
              state        <= LOCKED;
              block_lock_r <= 1'b1;
              sh_cnt       <= '0;
              invld_cnt    <= '0;
            end else begin
              sh_cnt <= sh_next;
            end
          end
        end
        LOCKED: begin
          if (hdr_strobe) begin
            if (hdr_invalid && (err_cnt_r != 8'hFF)) begin
              err_cnt_r <= err_cnt_r + 8'd1;
            end
            // Losing lock takes priority over a coincident window end.
            if (hdr_invalid && (invld_next == INVLD_MAX_V)) begin
              state        <= SLIP;
              block_lock_r <= 1'b0;
              sh_cnt       <= '0;
              invld_cnt    <= '0;
            end else if (sh_next == LOCK_CNT_V) begin
              sh_cnt    <= '0;
              invld_cnt <= '0;
            end else begin
              sh_cnt    <= sh_next;
              invld_cnt <= invld_next;
            end
          end
        end
        SLIP: begin
          pma_slip_r   <= 1'b1;
          block_lock_r <= 1'b0;
          hold_cnt     <= HO_W'(1);
          state        <= SLIP_WAIT;
        end
        SLIP_WAIT: begin
          if (hold_next == SLIP_HOLDOFF_V) begin
            hold_cnt <= '0;
            state    <= RESET_CNT;
          end else begin
            hold_cnt <= hold_next;
          end
        end
        default: begin
          state <= RESET_CNT;
        end
      endcase
    end
  end

  pcs_rx_ber_mon #(
    .BER_WINDOW (BER_WINDOW),
    .BER_MAX    (BER_MAX)
  ) u_ber_mon (
    .clk         (clk),
    .rst         (rst),
    .en          (block_lock_r),
    .hdr_strobe  (hdr_strobe),
    .hdr_invalid (hdr_invalid),
    .hi_ber      (hi_ber_w)
  );

  assign bus.pma_slip   = pma_slip_r;
  assign bus.block_lock = block_lock_r;
  assign bus.hi_ber     = hi_ber_w;
  assign bus.err_cnt    = err_cnt_r;

endmodule

// File: tb/tb_pcs_rx_block_lock.sv
// Directed bench for pcs_rx_block_lock: lock acquisition, slip timing, loss of
// lock, BER windows (shortened to 100 blocks), reset and err_cnt saturation.
module tb_pcs_rx_block_lock;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_strobe_cyc = 0;
  int   slip_total = 0;
  int   slip_b2b = 0;
  int   slip_q[$];
  logic prev_slip = 1'b0;

  pcs_rx_block_lock_if bus();

  pcs_rx_block_lock #(
    .LOCK_CNT     (64),
    .INVLD_MAX    (16),
    .SLIP_HOLDOFF (8),
    .BER_WINDOW   (100),
    .BER_MAX      (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Slip pulse recorder: cycle stamp of each pulse and any back-to-back pulses.
  always @(negedge clk) begin
    if (bus.pma_slip === 1'b1) begin
      slip_total <= slip_total + 1;
      slip_q.push_back(cyc);
      if (prev_slip) slip_b2b <= slip_b2b + 1;
    end
    prev_slip <= (bus.pma_slip === 1'b1);
  end

  task automatic checkOutput(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] h, input int gap);
    bus.hdr       = h;
    bus.hdr_valid = 1'b1;
    @(negedge clk);
    last_strobe_cyc = cyc;
    bus.hdr_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic sendBlock(input int n_inv, input int n_val);
    for (int i = 0; i < n_inv; i++) applyStimulus((i % 2 == 0) ? 2'b00 : 2'b11, 1);
    for (int i = 0; i < n_val; i++) applyStimulus((i % 2 == 0) ? 2'b01 : 2'b10, 1);
  endtask

  task automatic lockUp(input string tag);
    sendBlock(0, 63);
    checkOutput({tag, "_prelock"}, int'(bus.block_lock), 0);
    applyStimulus(2'b10, 0);
    checkOutput({tag, "_lock"}, int'(bus.block_lock), 1);
  endtask

  initial begin
    int n0;
    int slip_cyc;
    rst = 1'b0;
    bus.hdr = 2'b00;
    bus.hdr_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_slip", int'(bus.pma_slip), 0);
    checkOutput("rst_lock", int'(bus.block_lock), 0);
    checkOutput("rst_hiber", int'(bus.hi_ber), 0);
    checkOutput("rst_err", int'(bus.err_cnt), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] test 1: lock on 64 valid headers");
    lockUp("t1");
    checkOutput("t1_noslip", slip_total, 0);
    checkOutput("t1_hiber", int'(bus.hi_ber), 0);
    checkOutput("t1_err", int'(bus.err_cnt), 0);

    $display("[TB] test 2: slip on invalid header while hunting");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    sendBlock(0, 2);
    applyStimulus(2'b11, 0);
    slip_cyc = last_strobe_cyc + 1;
    checkOutput("t2_slip_early", int'(bus.pma_slip), 0);
    @(negedge clk);
    checkOutput("t2_slip", int'(bus.pma_slip), 1);
    checkOutput("t2_slip_cyc", cyc, slip_cyc);
    // Invalid headers inside the holdoff must not trigger another slip.
    bus.hdr = 2'b11;
    bus.hdr_valid = 1'b1;
    repeat (7) @(negedge clk);
    bus.hdr_valid = 1'b0;
    @(negedge clk);
    lockUp("t2");
    checkOutput("t2_one_slip", slip_total, 1);

    $display("[TB] test 3: invalid headers while locked");
    sendBlock(15, 49);
    checkOutput("t3_keep_lock", int'(bus.block_lock), 1);
    checkOutput("t3_err15", int'(bus.err_cnt), 15);
    sendBlock(0, 4);
    sendBlock(15, 0);
    checkOutput("t3_lock_pre", int'(bus.block_lock), 1);
    applyStimulus(2'b00, 0);
    checkOutput("t3_unlock", int'(bus.block_lock), 0);
    checkOutput("t3_err31", int'(bus.err_cnt), 31);
    @(negedge clk);
    checkOutput("t3_slip", int'(bus.pma_slip), 1);
    repeat (12) @(negedge clk);
    checkOutput("t3_hiber_off", int'(bus.hi_ber), 0);
    checkOutput("t3_two_slips", slip_total, 2);
    lockUp("t3r");

    $display("[TB] test 4: BER window");
    sendBlock(8, 56);
    sendBlock(8, 28);
    checkOutput("t4_hiber_set", int'(bus.hi_ber), 1);
    checkOutput("t4_lock", int'(bus.block_lock), 1);
    sendBlock(0, 99);
    checkOutput("t4_hiber_held", int'(bus.hi_ber), 1);
    applyStimulus(2'b01, 0);
    checkOutput("t4_hiber_clr", int'(bus.hi_ber), 0);
    checkOutput("t4_err", int'(bus.err_cnt), 47);

    $display("[TB] test 6: reset mid-window");
    sendBlock(8, 48);
    sendBlock(8, 0);
    checkOutput("t6_hiber", int'(bus.hi_ber), 1);
    checkOutput("t6_lock", int'(bus.block_lock), 1);
    checkOutput("t6_err", int'(bus.err_cnt), 63);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checkOutput("t6_rst_slip", int'(bus.pma_slip), 0);
    checkOutput("t6_rst_lock", int'(bus.block_lock), 0);
    checkOutput("t6_rst_hiber", int'(bus.hi_ber), 0);
    checkOutput("t6_rst_err", int'(bus.err_cnt), 0);
    repeat (2) @(negedge clk);
    lockUp("t6r");
    checkOutput("t6r_hiber", int'(bus.hi_ber), 0);

    $display("[TB] test 5: continuous invalid headers");
    n0 = slip_q.size();
    bus.hdr = 2'b11;
    bus.hdr_valid = 1'b1;
    repeat (60) @(negedge clk);
    checkOutput("t5_lock", int'(bus.block_lock), 0);
    bus.hdr_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("t5_err", int'(bus.err_cnt), 16);
    checkOutput("t5_npulses", slip_q.size() - n0, 5);
    for (int i = n0 + 1; i < slip_q.size(); i++) begin
      checkOutput("t5_spacing", slip_q[i] - slip_q[i-1], 10);
    end

    $display("[TB] test 7: err_cnt saturation");
    repeat (12) @(negedge clk);
    lockUp("t7");
    for (int w = 0; w < 18; w++) sendBlock(15, 49);
    checkOutput("t7_lock", int'(bus.block_lock), 1);
    checkOutput("t7_err_sat", int'(bus.err_cnt), 255);
    checkOutput("slip_b2b", slip_b2b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
